// File: rtl/debug_dma_engine_mt_if.sv
// Bundle of the host command, IU fetch/commit and status signals of the
// multi-thread debug DMA engine.
interface debug_dma_engine_mt_if #(
  parameter int NTHREAD = 64,
  parameter int TIDW    = $clog2(NTHREAD),
  parameter int BUFAW   = 10
) ();

  // Host command side
  logic [TIDW-1:0]  cmd_tid;
  logic             cmd_addr_we;
  logic [29:0]      cmd_addr;
  logic             cmd_addr_par;
  logic             cmd_ctrl_we;
  logic [BUFAW-1:0] cmd_buf_addr;
  logic [BUFAW-1:0] cmd_count;
  logic             cmd_dir;
  logic             cmd_go;
  logic             cmd_ctrl_par;

  // IU fetch side
  logic             if_valid;
  logic [TIDW-1:0]  if_tid;
  logic             if_inject;
  logic [31:0]      if_inst;
  logic [29:0]      if_addr;
  logic [BUFAW-1:0] if_buf_addr;
  logic [BUFAW-1:0] if_count;

  // IU commit side
  logic             xc_valid;
  logic [TIDW-1:0]  xc_tid;
  logic             xc_ack;

  // Status
  logic             done;
  logic [TIDW-1:0]  done_tid;
  logic             perr;
  logic [TIDW-1:0]  perr_tid;
  logic             busy;

  // Host/IU side driving commands, fetch slots and commit acks
  modport master (
    output cmd_tid, cmd_addr_we, cmd_addr, cmd_addr_par, cmd_ctrl_we,
           cmd_buf_addr, cmd_count, cmd_dir, cmd_go, cmd_ctrl_par,
           if_valid, if_tid, xc_valid, xc_tid, xc_ack,
    input  if_inject, if_inst, if_addr, if_buf_addr, if_count,
           done, done_tid, perr, perr_tid, busy
  );

  // DMA engine side
  modport slave (
    input  cmd_tid, cmd_addr_we, cmd_addr, cmd_addr_par, cmd_ctrl_we,
           cmd_buf_addr, cmd_count, cmd_dir, cmd_go, cmd_ctrl_par,
           if_valid, if_tid, xc_valid, xc_tid, xc_ack,
    output if_inject, if_inst, if_addr, if_buf_addr, if_count,
           done, done_tid, perr, perr_tid, busy
  );

endinterface

// File: rtl/debug_dma_engine_mt.sv
// Multi-thread debug DMA engine: one address/control context per hardware
// thread, LD/ST injection at fetch, context advance on commit acknowledge.
module debug_dma_engine_mt #(
  parameter int          NTHREAD = 64,
  parameter int          TIDW    = $clog2(NTHREAD),
  parameter int          BUFAW   = 10,
  parameter logic [31:0] INST_LD = 32'hC000_0000,
  parameter logic [31:0] INST_ST = 32'hC020_0000
) (
  input logic                   gclk,
  input logic                   rst,
  debug_dma_engine_mt_if.slave  bus
);

  typedef enum logic {
    ST_NOP = 1'b0,
    ST_OP  = 1'b1
  } state_e;

  typedef struct packed {
    logic [29:0]      addr;
    logic [BUFAW-1:0] buf_addr;
    logic [BUFAW-1:0] count;
    logic             dir;
    state_e           cmd;
  } ctx_t;

  ctx_t ctx [NTHREAD];

  // Decoded command/ack for this cycle and the contexts they produce
  logic            addr_acc, ctrl_acc, wr_acc, go_ok;
  logic            ack_acc, ack_last;
  logic            perr_nxt, done_nxt;
  logic            act_inc, act_dec;
  ctx_t            wr_old, wr_new, ak_old, ak_new, fe_ctx;
  logic [TIDW:0]   active_cnt, active_nxt;

  // Next-state for the written thread and the acknowledged thread
  always_comb begin
    // NOTE: every signal of a combinational block gets a default first, so
    // no path through the branches can leave it unassigned and infer a latch.
    addr_acc = bus.cmd_addr_we & ~(^{bus.cmd_addr, bus.cmd_addr_par});
    ctrl_acc = bus.cmd_ctrl_we & ~(^{bus.cmd_buf_addr, bus.cmd_count, bus.cmd_dir,
                                     bus.cmd_go, bus.cmd_ctrl_par});
    wr_acc   = addr_acc | ctrl_acc;
    perr_nxt = (bus.cmd_addr_we & ~addr_acc) | (bus.cmd_ctrl_we & ~ctrl_acc);
    go_ok    = bus.cmd_go & (bus.cmd_count != '0);

    wr_old = ctx[bus.cmd_tid];
    wr_new = wr_old;
    if (addr_acc) wr_new.addr = bus.cmd_addr;
    if (ctrl_acc) begin
      wr_new.buf_addr = bus.cmd_buf_addr;
      wr_new.count    = bus.cmd_count;
      wr_new.dir      = bus.cmd_dir;
      wr_new.cmd      = go_ok ? ST_OP : ST_NOP;
    end

    // A command write to the same thread wins over its ack
    ak_old   = ctx[bus.xc_tid];
    ack_acc  = bus.xc_valid & bus.xc_ack & (ak_old.cmd == ST_OP) &
               ~(wr_acc & (bus.cmd_tid == bus.xc_tid));
    ack_last = (ak_old.count == BUFAW'(1));
    ak_new          = ak_old;
    ak_new.addr     = ak_old.addr + 30'd1;
    ak_new.buf_addr = ak_old.buf_addr + BUFAW'(1);
    ak_new.count    = ak_old.count - BUFAW'(1);
    if (ack_last) ak_new.cmd = ST_NOP;
    done_nxt = ack_acc & ack_last;

    act_inc    = ctrl_acc & go_ok & (wr_old.cmd == ST_NOP);
    act_dec    = (ctrl_acc & ~go_ok & (wr_old.cmd == ST_OP)) | done_nxt;
    active_nxt = active_cnt + (TIDW+1)'(act_inc) - (TIDW+1)'(act_dec);
  end

  // Fetch view of the addressed thread, forwarded from this cycle's update
  always_comb begin
    fe_ctx = ctx[bus.if_tid];
    if (wr_acc && (bus.cmd_tid == bus.if_tid))
      fe_ctx = wr_new;
    else if (ack_acc && (bus.xc_tid == bus.if_tid))
      fe_ctx = ak_new;
  end

  // Per-thread context state registers
  always_ff @(posedge gclk) begin
    if (rst) begin
      // NOTE: the context array is a flop array, not a RAM, so every entry is
      // reset; a reset must abort all threads at once.
      for (int i = 0; i < NTHREAD; i++) ctx[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (wr_acc)  ctx[bus.cmd_tid] <= wr_new;
      if (ack_acc) ctx[bus.xc_tid]  <= ak_new;
    end
  end

  // Registered fetch, status pulses and active-thread count
  always_ff @(posedge gclk) begin
    if (rst) begin
      bus.if_inject   <= 1'b0;
      bus.if_inst     <= '0;
      bus.if_addr     <= '0;
      bus.if_buf_addr <= '0;
      bus.if_count    <= '0;
      bus.done        <= 1'b0;
      bus.done_tid    <= '0;
      bus.perr        <= 1'b0;
      bus.perr_tid    <= '0;
      bus.busy        <= 1'b0;
      active_cnt      <= '0;
    end else begin
      bus.if_inject   <= bus.if_valid & (fe_ctx.cmd == ST_OP);
      bus.if_inst     <= (bus.if_valid & (fe_ctx.cmd == ST_OP)) ?
                         (fe_ctx.dir ? INST_ST : INST_LD) : '0;
      bus.if_addr     <= fe_ctx.addr;
      bus.if_buf_addr <= fe_ctx.buf_addr;
      bus.if_count    <= fe_ctx.count;
      bus.done        <= done_nxt;
      bus.done_tid    <= done_nxt ? bus.xc_tid : '0;
      bus.perr        <= perr_nxt;
      bus.perr_tid    <= perr_nxt ? bus.cmd_tid : '0;
      bus.busy        <= (active_nxt != '0);
      active_cnt      <= active_nxt;
    end
  end

endmodule

// File: tb/tb_debug_dma_engine_mt.sv
// Self-checking bench for debug_dma_engine_mt: directed scenarios followed by
// randomized traffic, all compared against a thread-array reference model.
module tb_debug_dma_engine_mt;

  localparam int          NT      = 64;
  localparam int          TIDW    = $clog2(NT);
  localparam int          BUFAW   = 10;
  localparam logic [31:0] INST_LD = 32'hC000_0000;
  localparam logic [31:0] INST_ST = 32'hC020_0000;

  logic gclk = 1'b0;
  logic rst  = 1'b1;
  always #5 gclk = ~gclk;

  debug_dma_engine_mt_if #(.NTHREAD(NT), .BUFAW(BUFAW)) bus ();

  debug_dma_engine_mt #(
    .NTHREAD(NT), .BUFAW(BUFAW), .INST_LD(INST_LD), .INST_ST(INST_ST)
  ) dut (
    .gclk (gclk),
    .rst  (rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per thread
  logic [29:0]      m_addr [NT];
  logic [BUFAW-1:0] m_bufa [NT];
  logic [BUFAW-1:0] m_cnt  [NT];
  bit               m_dir  [NT];
  bit               m_op   [NT];

  // Expected registered outputs
  logic             e_inject, e_done, e_perr, e_busy;
  logic [31:0]      e_inst;
  logic [29:0]      e_addr;
  logic [BUFAW-1:0] e_bufa, e_cnt;
  logic [TIDW-1:0]  e_done_tid, e_perr_tid;
  int               e_active;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cmd_tid = '0; bus.cmd_addr_we = 1'b0; bus.cmd_addr = '0; bus.cmd_addr_par = 1'b0;
    bus.cmd_ctrl_we = 1'b0; bus.cmd_buf_addr = '0; bus.cmd_count = '0; bus.cmd_dir = 1'b0;
    bus.cmd_go = 1'b0; bus.cmd_ctrl_par = 1'b0;
    bus.if_valid = 1'b0; bus.if_tid = '0;
    bus.xc_valid = 1'b0; bus.xc_tid = '0; bus.xc_ack = 1'b0;
  endtask

  task automatic set_addr(input int tid, input logic [29:0] a, input bit bad);
    bus.cmd_tid      = TIDW'(tid);
    bus.cmd_addr_we  = 1'b1;
    bus.cmd_addr     = a;
    bus.cmd_addr_par = (^a) ^ bad;
  endtask

  task automatic set_ctrl(input int tid, input int ba, input int cnt, input bit dir,
                          input bit go, input bit bad);
    bus.cmd_tid      = TIDW'(tid);
    bus.cmd_ctrl_we  = 1'b1;
    bus.cmd_buf_addr = BUFAW'(ba);
    bus.cmd_count    = BUFAW'(cnt);
    bus.cmd_dir      = dir;
    bus.cmd_go       = go;
    bus.cmd_ctrl_par = (^{BUFAW'(ba), BUFAW'(cnt), dir, go}) ^ bad;
  endtask

  task automatic set_ack(input int tid);
    bus.xc_valid = 1'b1; bus.xc_ack = 1'b1; bus.xc_tid = TIDW'(tid);
  endtask

  task automatic set_fetch(input int tid);
    bus.if_valid = 1'b1; bus.if_tid = TIDW'(tid);
  endtask

  // Apply the rules to the model, clock once, compare every output.
  task automatic tick();
    bit a_ok, c_ok, wa, wc, ack;
    int t, x, f;
    if (rst) begin
      for (int i = 0; i < NT; i++) begin
        m_addr[i] = '0; m_bufa[i] = '0; m_cnt[i] = '0; m_dir[i] = 1'b0; m_op[i] = 1'b0;
      end
      e_inject = 0; e_inst = '0; e_addr = '0; e_bufa = '0; e_cnt = '0;
      e_done = 0; e_done_tid = '0; e_perr = 0; e_perr_tid = '0; e_busy = 0; e_active = 0;
    end else begin
      t    = int'(bus.cmd_tid);
      x    = int'(bus.xc_tid);
      f    = int'(bus.if_tid);
      a_ok = ((^bus.cmd_addr) == bus.cmd_addr_par);
      c_ok = ((^{bus.cmd_buf_addr, bus.cmd_count, bus.cmd_dir, bus.cmd_go}) == bus.cmd_ctrl_par);
      wa   = bus.cmd_addr_we && a_ok;
      wc   = bus.cmd_ctrl_we && c_ok;
      e_perr     = (bus.cmd_addr_we && !a_ok) || (bus.cmd_ctrl_we && !c_ok);
      e_perr_tid = bus.cmd_tid;
      ack  = bus.xc_valid && bus.xc_ack && m_op[x] && !((wa || wc) && t == x);
      e_done     = ack && (m_cnt[x] == 1);
      e_done_tid = bus.xc_tid;
      if (ack) begin
        if (m_cnt[x] == 1) m_op[x] = 1'b0;
        m_addr[x] = m_addr[x] + 1;
        m_bufa[x] = m_bufa[x] + 1;
        m_cnt[x]  = m_cnt[x] - 1;
      end
      if (wa) m_addr[t] = bus.cmd_addr;
      if (wc) begin
        m_bufa[t] = bus.cmd_buf_addr;
        m_cnt[t]  = bus.cmd_count;
        m_dir[t]  = bus.cmd_dir;
        m_op[t]   = bus.cmd_go && (bus.cmd_count != 0);
      end
      e_active = 0;
      for (int i = 0; i < NT; i++) e_active += int'(m_op[i]);
      e_busy   = (e_active != 0);
      e_inject = bus.if_valid && m_op[f];
      e_inst   = !e_inject ? 32'h0 : (m_dir[f] ? INST_ST : INST_LD);
      e_addr   = m_addr[f];
      e_bufa   = m_bufa[f];
      e_cnt    = m_cnt[f];
    end
    @(posedge gclk);
    #1;
    chk("if_inject", bus.if_inject, e_inject);
    chk("if_inst", bus.if_inst, e_inst);
    chk("if_addr", bus.if_addr, e_addr);
    chk("if_buf_addr", bus.if_buf_addr, e_bufa);
    chk("if_count", bus.if_count, e_cnt);
    chk("done", bus.done, e_done);
    if (e_done) chk("done_tid", bus.done_tid, e_done_tid);
    chk("perr", bus.perr, e_perr);
    if (e_perr) chk("perr_tid", bus.perr_tid, e_perr_tid);
    chk("busy", bus.busy, e_busy);
    chk("active_cnt", dut.active_cnt, e_active);
    idle_inputs();
  endtask

  initial begin
    int tid;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("reset_busy", bus.busy, 0);
    chk("reset_inject", bus.if_inject, 0);
    rst = 1'b0;

    // Thread 3: three-word LD from 0x100 into buffer word 5
    set_addr(3, 30'h100, 0);
    set_ctrl(3, 5, 3, 0, 1, 0);
    tick();
    set_fetch(3);
    tick();
    chk("t3_inject", bus.if_inject, 1);
    chk("t3_inst", bus.if_inst, INST_LD);
    chk("t3_addr", bus.if_addr, 30'h100);
    for (int k = 1; k <= 3; k++) begin
      set_ack(3);
      set_fetch(3);
      tick();
      chk("t3_seq_addr", bus.if_addr, 30'h100 + k);
      chk("t3_seq_buf", bus.if_buf_addr, 5 + k);
    end
    chk("t3_done", bus.done, 1);
    chk("t3_done_tid", bus.done_tid, 3);
    chk("t3_busy", bus.busy, 0);
    tick();
    chk("t3_done_once", bus.done, 0);

    // Bad control parity on thread 7 is dropped and flagged
    set_ctrl(7, 0, 3, 0, 1, 1);
    tick();
    chk("t7_perr", bus.perr, 1);
    chk("t7_perr_tid", bus.perr_tid, 7);
    chk("t7_busy", bus.busy, 0);
    set_fetch(7);
    tick();
    chk("t7_nop", bus.if_inject, 0);

    // Address and buffer wrap on thread 9, ST direction
    set_addr(9, 30'h3FFF_FFFF, 0);
    set_ctrl(9, 1023, 2, 1, 1, 0);
    tick();
    set_ack(9);
    set_fetch(9);
    tick();
    chk("wrap_addr", bus.if_addr, 0);
    chk("wrap_buf", bus.if_buf_addr, 0);
    chk("wrap_count", bus.if_count, 1);
    chk("wrap_inst", bus.if_inst, INST_ST);
    set_ctrl(9, 0, 0, 0, 0, 0);
    tick();

    // Control write beats an ack on thread 2 sitting at count 1
    set_ctrl(2, 0, 1, 0, 1, 0);
    tick();
    set_ctrl(2, 0, 4, 0, 1, 0);
    set_ack(2);
    set_fetch(2);
    tick();
    chk("coll_count", bus.if_count, 4);
    chk("coll_inject", bus.if_inject, 1);
    chk("coll_done", bus.done, 0);
    set_ctrl(2, 0, 0, 0, 0, 0);
    tick();

    // Start on thread 2 alongside the final ack of thread 0
    set_ctrl(0, 0, 1, 0, 1, 0);
    tick();
    set_ctrl(1, 0, 3, 0, 1, 0);
    tick();
    set_ctrl(2, 0, 2, 0, 1, 0);
    set_ack(0);
    tick();
    chk("swap_done", bus.done, 1);
    chk("swap_busy", bus.busy, 1);
    chk("swap_active", dut.active_cnt, 2);

    // Reset mid-transfer aborts everything without a done pulse
    rst = 1'b1;
    set_ack(1);
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    set_fetch(1);
    tick();
    chk("rst_nop", bus.if_inject, 0);

    // Zero count with go stays idle; ack to an idle thread is ignored
    set_addr(5, 30'h55, 0);
    set_ctrl(5, 3, 0, 0, 1, 0);
    tick();
    chk("zero_busy", bus.busy, 0);
    set_ack(5);
    set_fetch(5);
    tick();
    chk("idle_addr", bus.if_addr, 30'h55);
    chk("idle_done", bus.done, 0);
    chk("idle_inject", bus.if_inject, 0);

    // Randomized traffic over a few threads so collisions are frequent
    for (int n = 0; n < 600; n++) begin
      rst = (n == 300);
      if ($urandom_range(0, 2) == 0) begin
        tid = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1)
          set_addr(tid, ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE : 30'($urandom),
                   $urandom_range(0, 9) == 0);
        if ($urandom_range(0, 1) == 1)
          set_ctrl(tid, $urandom_range(0, 1023), $urandom_range(0, 4),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 4) != 0,
                   $urandom_range(0, 9) == 0);
      end
      bus.xc_valid = ($urandom_range(0, 3) != 0);
      bus.xc_ack   = ($urandom_range(0, 3) != 0);
      bus.xc_tid   = TIDW'($urandom_range(0, 7));
      bus.if_valid = ($urandom_range(0, 1) == 1);
      bus.if_tid   = TIDW'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_dma_engine_mt.md
Name: debug_dma_engine_mt

Overview:
- Multi-thread, parametrised successor to the single-register on-chip debug DMA state.
- Holds one address/control context per hardware thread and injects LD or ST instructions at ifetch for threads with an active DMA.
- Advances each context on commit acknowledges from the xc/com stage, and reports per-thread completion and parity errors.
- Sits between the debug command interface (host side) and the IU fetch/commit stages.

Parameters:
- NTHREAD, 64, number of hardware thread contexts (power of 2, ≥2).
- TIDW, $clog2(NTHREAD), thread ID width.
- BUFAW, 10, DMA buffer word-address width; the count field uses the same width.
- INST_LD, 32'hC000_0000, instruction word injected for memory→buffer transfers.
- INST_ST, 32'hC020_0000, instruction word injected for buffer→memory transfers.

Ports:
- gclk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_tid  in  TIDW  target thread for command writes.
- cmd_addr_we  in  1  write the address register.
- cmd_addr  in  30  word-aligned virtual address.
- cmd_addr_par  in  1  even parity over cmd_addr.
- cmd_ctrl_we  in  1  write the control register.
- cmd_buf_addr  in  BUFAW  starting buffer word.
- cmd_count  in  BUFAW  number of words to transfer.
- cmd_dir  in  1  0 = LD (memory→buffer), 1 = ST.
- cmd_go  in  1  1 = start operation, 0 = abort to NOP.
- cmd_ctrl_par  in  1  even parity over {cmd_buf_addr, cmd_count, cmd_dir, cmd_go}.
- if_valid  in  1  fetch slot valid.
- if_tid  in  TIDW  thread being fetched.
- if_inject  out  1  registered; injected instruction valid.
- if_inst  out  32  injected instruction.
- if_addr  out  30  current address of the fetched thread.
- if_buf_addr  out  BUFAW  current buffer word of the fetched thread.
- if_count  out  BUFAW  words remaining for the fetched thread.
- xc_valid  in  1  commit slot valid.
- xc_tid  in  TIDW  committing thread.
- xc_ack  in  1  injected access completed; advance the context.
- done  out  1  one-cycle pulse when a thread's transfer finishes.
- done_tid  out  TIDW  thread that finished.
- perr  out  1  one-cycle pulse when a command write is rejected for bad parity.
- perr_tid  out  TIDW  thread whose command write was rejected.
- busy  out  1  at least one thread is in the OP state.

Behaviour:
- Reset: each context is set to addr = 0, buf_addr = 0, count = 0, dir = 0, cmd = NOP, and the active-thread counter is cleared. All outputs are 0 in the cycle after rst is high. Reset mid-transfer aborts every context; done is not pulsed.
- Per-thread FSM has two states, NOP and OP.
  - NOP→OP: accepted ctrl write with cmd_go = 1 and cmd_count ≠ 0.
  - OP→NOP: ack on the last word, or accepted ctrl write with cmd_go = 0 (abort, no done pulse).
  - A ctrl write with cmd_go = 1 and cmd_count = 0 forces NOP; no done pulse.
- Parity check:
  - A write whose parity mismatches is dropped, leaving the context unchanged.
  - perr pulses the next cycle with perr_tid = cmd_tid.
  - If the addr and ctrl writes occur in the same cycle, each is checked independently. perr pulses once if either fails.
- Fetch timing:
  - Registered with 1-cycle latency: the if_* outputs at cycle N+1 reflect if_tid at cycle N.
  - if_inject = if_valid & (cmd == OP).
  - if_inst = INST_ST when dir = 1, else INST_LD. When if_inject = 0, if_inst = 0.
  - if_addr, if_buf_addr and if_count are always driven from the context.
- Commit (xc_valid & xc_ack, context in OP):
  - addr ← addr + 1 (mod 2^30).
  - buf_addr ← buf_addr + 1 (mod 2^BUFAW).
  - count ← count − 1.
  - If the old count = 1: cmd ← NOP, and done pulses the next cycle with done_tid = xc_tid.
  - An ack to a NOP context is ignored.
- Forwarding: when if_tid = xc_tid in the same cycle, the fetch output uses the post-update context.
- Collision: a command write and an ack to the same thread in the same cycle → the command write wins and the ack is discarded. Writes and acks to different threads both take effect.
- Active-thread counter:
  - Width TIDW+1.
  - +1 on each NOP→OP transition, −1 on each OP→NOP transition.
  - Simultaneous +1 and −1 on different threads leaves it unchanged.
  - busy = (counter ≠ 0), registered.

Test Plan:
- Thread 3: addr = 0x100, buf = 5, count = 3, dir = 0, go; fetch tid 3 → if_inject = 1, if_inst = INST_LD, if_addr = 0x100. After 3 acks the addr/buf sequence is 0x101/6, 0x102/7, 0x103/8. done pulses once with done_tid = 3 on the cycle after the 3rd ack; busy drops.
- Wrap: addr = 0x3FFF_FFFF, buf = 1023, count = 2, dir = 1; one ack → addr = 0, buf = 0, count = 1, and if_inst = INST_ST.
- Bad cmd_ctrl_par on tid 7 with go → perr = 1 and perr_tid = 7 next cycle; tid 7 stays NOP; busy stays 0.
- Ctrl write (count = 4) and ack to tid 2 in the same cycle, with tid 2 previously at count = 1 → count = 4, state OP, no done pulse.
- Threads 0 and 1 active; a go to tid 2 and the final ack of tid 0 in the same cycle → busy stays 1 with the counter = 2. rst asserted mid-transfer → all contexts NOP, busy = 0, no done pulse.
- count = 0 with go → thread stays NOP, no done pulse. An ack to an idle thread leaves its context unchanged.
